// File: rtl/pipe_alu_gen.sv
// pipe_alu_gen: three-stage ALU pipeline (operand read/forward, execute, write back)
// feeding a resettable register bank and a non-reset data memory.
module pipe_alu_gen #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] z,
    output logic              z_valid,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);
    localparam int REG_N = 2 ** REG_AW;
    localparam int MEM_N = 2 ** MEM_AW;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_PASS_A, OP_PASS_B, OP_AND,
        OP_OR, OP_XOR, OP_NEG_A, OP_NEG_B, OP_SHR_A, OP_SHL_A
    } alu_op_e;

    logic [DATA_W-1:0] regbank [REG_N];
    logic [DATA_W-1:0] mem     [MEM_N];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [REG_AW-1:0] s1_rd;
    logic [3:0]        s1_func;
    logic [MEM_AW-1:0] s1_addr;
    logic [REG_AW-1:0] s2_rd;
    logic [MEM_AW-1:0] s2_addr;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] opa, opb;
    logic              accept;
    logic              wr_en;

    assign in_ready = ~hold;
    assign accept   = in_valid & ~hold;
    assign wr_en    = z_valid & ~hold;

    always_comb begin
        // NOTE: default assigned first so every path drives alu_res; no latch is inferred.
        alu_res = '0;
        case (s1_func)
            OP_ADD:    alu_res = s1_a + s1_b;
            OP_SUB:    alu_res = s1_a - s1_b;
            OP_MUL:    alu_res = s1_a * s1_b;
            OP_PASS_A: alu_res = s1_a;
            OP_PASS_B: alu_res = s1_b;
            OP_AND:    alu_res = s1_a & s1_b;
            OP_OR:     alu_res = s1_a | s1_b;
            OP_XOR:    alu_res = s1_a ^ s1_b;
            OP_NEG_A:  alu_res = -s1_a;
            OP_NEG_B:  alu_res = -s1_b;
            OP_SHR_A:  alu_res = s1_a >> 1;
            OP_SHL_A:  alu_res = s1_a << 1;
            default:   alu_res = '0;
        endcase
    end

    // Youngest producer wins: the instruction in S1 shadows the one in S2, which shadows the bank.
    always_comb begin
        if (s1_valid && s1_rd == rs1)     opa = alu_res;
        else if (z_valid && s2_rd == rs1) opa = z;
        else                              opa = regbank[rs1];
    end

    always_comb begin
        if (s1_valid && s1_rd == rs2)     opb = alu_res;
        else if (z_valid && s2_rd == rs2) opb = z;
        else                              opb = regbank[rs2];
    end

    // NOTE: all clocked state uses non-blocking assignments so stages read pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
            s1_func  <= '0;
            s1_addr  <= '0;
        end else if (!hold) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_a    <= opa;
                s1_b    <= opb;
                s1_rd   <= rd;
                s1_func <= func;
                s1_addr <= addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z       <= '0;
            z_valid <= 1'b0;
            s2_rd   <= '0;
            s2_addr <= '0;
        end else if (!hold) begin
            z       <= alu_res;
            z_valid <= s1_valid;
            s2_rd   <= s1_rd;
            s2_addr <= s1_addr;
        end
    end

    // NOTE: the register bank resets to its index; the data memory has no reset so it can map to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_N; k++) regbank[k] <= DATA_W'(k);
        end else if (wr_en) begin
            regbank[s2_rd] <= z;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[s2_addr] <= z;
    end

    assign dbg_rdata = regbank[dbg_raddr];
    assign mem_rdata = mem[mem_raddr];

endmodule
